ual_arbiter: RTL and testbench
==============================

Name: ual_arbiter

Overview:
- Two-requester, round-robin arbiter and sequencer around one combinational `ual` instance (NAND/XOR/ADD/SUB/MUL, 4-bit operands, 8-bit result, ZF/OF flags).
- Accepts at most one operation per cycle and drives the `ual` select.
- Registers result and flags into a single-entry response buffer tagged with the requester ID.
- Sits between the two operand-producing agents and the shared ALU, so that neither agent drives `ual` directly.

Parameters:
- CNT_W, 16, width of per-port saturating accepted-operation counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_in0  input  4  port 0 operand A.
- req0_in1  input  4  port 0 operand B.
- req0_sel  input  5  port 0 op, one-hot: 1 NAND, 2 XOR, 4 ADD, 8 SUB, 16 MUL.
- req1_valid, req1_ready, req1_in0, req1_in1, req1_sel  same as port 0, for port 1.
- rsp_valid  output  1  response buffer full.
- rsp_ready  input  1  consumer takes response.
- rsp_id  output  1  requester ID of the response (0/1).
- rsp_out  output  8  registered `ual` out.
- rsp_flags  output  2  registered `ual` flags; bit positions per `ZF`/`OF` in defines.vh.
- rsp_err  output  1  illegal sel (see Optional Feature).
- cnt0  output  CNT_W  accepted ops from port 0, saturating.
- cnt1  output  CNT_W  accepted ops from port 1, saturating.

Behaviour:
- Reset (async, immediate): rsp_valid=0, rsp_id=0, rsp_out=0, rsp_flags=0, rsp_err=0, cnt0=cnt1=0, last_grant=1 (port 0 wins first contention).
- While rst is high, req0_ready=req1_ready=0.
- Reset mid-operation drops any buffered response; nothing is replayed.
- Buffer free: `free = ~rsp_valid | rsp_ready`.
- Grant, combinational:
  - Only one port valid: grant that port.
  - Both valid: grant the port != last_grant.
  - Neither valid: no grant.
- reqN_ready = grantN & free. At most one ready is high per cycle.
- reqN_ready may depend on both valids. Requesters must not make valid depend on ready.
- Valid/ready protocol: once a request is valid, the requester holds valid and its payload stable until ready is high.
- Accept happens on a rising edge with reqN_valid & reqN_ready. On that edge:
  - Capture `ual` out/flags into rsp_out/rsp_flags, computed from the granted port's in0/in1/sel.
  - rsp_id=N; rsp_valid=1.
  - last_grant=N.
  - cntN += 1, holding at 2^CNT_W-1.
- Latency: rsp_valid is visible in the cycle after acceptance.
- Throughput: 1 op/cycle while rsp_ready=1.
- Drain: rsp_valid & rsp_ready with no accept on that edge → rsp_valid=0.
- Drain and accept on the same edge → buffer reloads; rsp_valid stays 1.
- Stall: rsp_valid=1 & rsp_ready=0 → rsp_* held stable; both readies 0; last_grant unchanged.
- A port that is not granted while both are valid keeps its request pending. Its valid stays high and it wins the next free cycle (no starvation, worst case one lost turn).
- Flags are exactly those `ual` produces for the captured operation:
  - ZF = out==0.
  - OF only for ADD/SUB signed 4-bit overflow.
- No combinational path from req* to rsp*.

Optional Feature:
- Macro UAL_ARB_ILLEGAL_CHECK_EN.
- Defined:
  - sel not in {1,2,4,8,16} is still accepted and counted.
  - The response carries rsp_err=1, rsp_out=0, rsp_flags=0.
  - Legal ops give rsp_err=0.
- Undefined:
  - rsp_err is tied to 0.
  - Illegal sel is forwarded to `ual`; rsp_out/rsp_flags are unspecified and are not checked.
  - Handshake and counters are unchanged.

Test Plan:
- Port 0 only, sel=1, in0=4'hA, in1=4'h5, rsp_ready=1 → next cycle: rsp_valid=1, rsp_id=0, rsp_out=8'h0F, ZF=0, OF=0; cnt0=1.
- Port 1 only, sel=4, in0=7, in1=1 → rsp_out=8'h08, OF=1, ZF=0, rsp_id=1.
- Port 1 only, sel=8, in0=3, in1=3 → rsp_out=0, ZF=1, OF=0.
- Port 1 only, sel=16, in0=15, in1=15 → rsp_out=8'hE1.
- Both ports valid for 4 cycles, rsp_ready=1:
  - Grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1 one cycle later.
  - cnt0=cnt1=2; never both readies high.
- Response stall and drain:
  - Hold rsp_ready=0 for 3 cycles with both ports valid → rsp_* stable, readies 0.
  - Raise rsp_ready → same-edge drain+accept; rsp_valid stays 1 with the new result.
- With UAL_ARB_ILLEGAL_CHECK_EN, sel=5'b00011 → rsp_err=1, rsp_out=0, rsp_flags=0, counter incremented.
- Reset mid-operation: assert rst mid-cycle with rsp_valid=1 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ual_arbiter.sv
// ual_arbiter: two-port round-robin arbiter in front of a shared combinational
// ALU (ual), with a single-entry registered response buffer tagged by requester.
// Optional build macro: UAL_ARB_ILLEGAL_CHECK_EN -- when defined, a non-one-hot
// sel is still accepted and counted, but answers with rsp_err=1, rsp_out=0 and
// rsp_flags=0. When undefined, rsp_err is tied low and the sel goes to ual as is.
// Flag bit positions: flags[0] = ZF (result zero), flags[1] = OF (signed overflow).

// ual: combinational NAND/XOR/ADD/SUB/MUL on 4-bit operands, 8-bit result.
module ual (
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [4:0] sel,
  output logic [7:0] out,
  output logic [1:0] flags
);
  localparam int unsigned ZF = 0;
  localparam int unsigned OF = 1;

  logic [4:0] sum;
  logic [3:0] diff;
  logic       ovf;

  // Operation decode, result and flag generation
  always_comb begin
    out  = '0;
    ovf  = 1'b0;
    sum  = {1'b0, in0} + {1'b0, in1};
    diff = in0 - in1;
    unique case (sel)
      5'd1:  out = {4'b0, ~(in0 & in1)};
      5'd2:  out = {4'b0, in0 ^ in1};
      5'd4: begin
        out = {3'b0, sum};
        ovf = (in0[3] == in1[3]) && (sum[3] != in0[3]);
      end
      5'd8: begin
        out = {4'b0, diff};
        ovf = (in0[3] != in1[3]) && (diff[3] != in0[3]);
      end
      5'd16: out = {4'b0, in0} * {4'b0, in1};
      default: out = '0;
    endcase
    flags     = '0;
    flags[ZF] = (out == 8'd0);
    flags[OF] = ovf;
  end
endmodule

module ual_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_in0,
  input  logic [3:0]       req0_in1,
  input  logic [4:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_in0,
  input  logic [3:0]       req1_in1,
  input  logic [4:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_out,
  output logic [1:0]       rsp_flags,
  output logic             rsp_err,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic       last_grant;
  logic       free;
  logic       grant0, grant1;
  logic       acc0, acc1, accept;
  logic [3:0] op_in0, op_in1;
  logic [4:0] op_sel;
  logic [7:0] alu_out;
  logic [1:0] alu_flags;
  logic [7:0] cap_out;
  logic [1:0] cap_flags;
  logic       cap_err;

  // Grant selection and handshake; the loser of a contention wins next time
  always_comb begin
    free       = ~rsp_valid | rsp_ready;
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = grant0 & free & ~rst;
    req1_ready = grant1 & free & ~rst;
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
    accept     = acc0 | acc1;
    op_in0     = grant1 ? req1_in0 : req0_in0;
    op_in1     = grant1 ? req1_in1 : req0_in1;
    op_sel     = grant1 ? req1_sel : req0_sel;
  end

  ual u_ual (
    .in0   (op_in0),
    .in1   (op_in1),
    .sel   (op_sel),
    .out   (alu_out),
    .flags (alu_flags)
  );

  // Response payload, optionally overridden for illegal selects
  always_comb begin
    cap_out   = alu_out;
    cap_flags = alu_flags;
    cap_err   = 1'b0;
`ifdef UAL_ARB_ILLEGAL_CHECK_EN
    if (!(op_sel inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16})) begin
      cap_out   = '0;
      cap_flags = '0;
      cap_err   = 1'b1;
    end
`endif
  end

  // Single-entry response buffer and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_out    <= '0;
      rsp_flags  <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= acc1;
      rsp_out    <= cap_out;
      rsp_flags  <= cap_flags;
      last_grant <= acc1;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef UAL_ARB_ILLEGAL_CHECK_EN
  logic err_q;

  // Error tag travels with the buffered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= cap_err;
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Saturating per-port accept counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (acc0 && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
      if (acc1 && cnt1 != '1) cnt1 <= cnt1 + 1'b1;
    end
  end
endmodule

// File: tb/tb_ual_arbiter.sv
// Directed bench for ual_arbiter (CNT_W overridden to 3 to reach saturation).
module tb_ual_arbiter;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]    req0_in0, req0_in1, req1_in0, req1_in1;
  logic [4:0]    req0_sel, req1_sel;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0]    rsp_out;
  logic [1:0]    rsp_flags;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  ual_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in0(req0_in0), .req0_in1(req0_in1), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in0(req1_in0), .req1_in1(req1_in1), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
    req0_valid = v; req0_in0 = a; req0_in1 = b; req0_sel = s;
  endtask

  task automatic set1(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
    req1_valid = v; req1_in0 = a; req1_in1 = b; req1_sel = s;
  endtask

  task automatic edge_sample();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    set0(1'b1, 4'h0, 4'h0, 5'd1);
    set1(1'b1, 4'h0, 4'h0, 5'd1);
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    set0(1'b0, 4'h0, 4'h0, 5'd1);
    set1(1'b0, 4'h0, 4'h0, 5'd1);
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;

    // Port 0 NAND A,5
    @(negedge clk); set0(1'b1, 4'hA, 4'h5, 5'd1);
    #1; chk("p0_ready", req0_ready, 1); chk("p0_ready1", req1_ready, 0);
    edge_sample();
    chk("nand_valid", rsp_valid, 1); chk("nand_id", rsp_id, 0);
    chk("nand_out", rsp_out, 8'h0F); chk("nand_flags", rsp_flags, 2'b00);
    chk("nand_err", rsp_err, 0); chk("nand_cnt0", cnt0, 1);
    @(negedge clk); set0(1'b0, 4'h0, 4'h0, 5'd1);
    edge_sample();
    chk("drain_valid", rsp_valid, 0);

    // Port 1 ADD overflow, SUB zero, MUL, back to back
    @(negedge clk); set1(1'b1, 4'd7, 4'd1, 5'd4);
    edge_sample();
    chk("add_out", rsp_out, 8'h08); chk("add_flags", rsp_flags, 2'b10); chk("add_id", rsp_id, 1);
    @(negedge clk); set1(1'b1, 4'd3, 4'd3, 5'd8);
    edge_sample();
    chk("sub_out", rsp_out, 8'h00); chk("sub_flags", rsp_flags, 2'b01); chk("sub_valid", rsp_valid, 1);
    @(negedge clk); set1(1'b1, 4'd15, 4'd15, 5'd16);
    edge_sample();
    chk("mul_out", rsp_out, 8'hE1); chk("mul_flags", rsp_flags, 2'b00); chk("mul_cnt1", cnt1, 3);

    // Contention: last grant was port 1, so port 0 goes first, then alternate
    @(negedge clk);
    set0(1'b1, 4'd3, 4'd5, 5'd2);
    set1(1'b1, 4'd2, 4'd2, 5'd4);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
      edge_sample();
      chk("rr_id", rsp_id, (k % 2 == 0) ? 0 : 1);
      chk("rr_out", rsp_out, (k % 2 == 0) ? 8'h06 : 8'h04);
      @(negedge clk);
    end
    chk("rr_cnt0", cnt0, 3); chk("rr_cnt1", cnt1, 5);

    // Stall with both valid, then same-edge drain + accept (port 0 next)
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready0", req0_ready, 0); chk("stall_ready1", req1_ready, 0);
      edge_sample();
      chk("stall_valid", rsp_valid, 1); chk("stall_id", rsp_id, 1); chk("stall_out", rsp_out, 8'h04);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1; chk("resume_ready0", req0_ready, 1);
    edge_sample();
    chk("reload_valid", rsp_valid, 1); chk("reload_id", rsp_id, 0);
    chk("reload_out", rsp_out, 8'h06); chk("reload_cnt0", cnt0, 4);

    // Illegal select from port 0 alone
    @(negedge clk); set1(1'b0, 4'h0, 4'h0, 5'd1); set0(1'b1, 4'd1, 4'd2, 5'b00011);
    edge_sample();
    chk("ill_cnt0", cnt0, 5); chk("ill_id", rsp_id, 0);
`ifdef UAL_ARB_ILLEGAL_CHECK_EN
    chk("ill_err", rsp_err, 1); chk("ill_out", rsp_out, 8'h00); chk("ill_flags", rsp_flags, 2'b00);
`else
    chk("ill_err", rsp_err, 0);
`endif

    // Asynchronous reset while a response is held
    @(negedge clk); set0(1'b0, 4'h0, 4'h0, 5'd1); rsp_ready = 1'b0;
    #2; rst = 1'b1; #1;
    chk("arst_valid", rsp_valid, 0); chk("arst_out", rsp_out, 0); chk("arst_flags", rsp_flags, 0);
    chk("arst_id", rsp_id, 0); chk("arst_err", rsp_err, 0);
    chk("arst_cnt0", cnt0, 0); chk("arst_cnt1", cnt1, 0);
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1;
    set0(1'b1, 4'd1, 4'd1, 5'd2); set1(1'b1, 4'd1, 4'd1, 5'd2);
    #1; chk("post_rst_ready0", req0_ready, 1); chk("post_rst_ready1", req1_ready, 0);

    // Saturation: eight port-0 accepts on a 3-bit counter stop at 7
    set1(1'b0, 4'h0, 4'h0, 5'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
    end
    #1; chk("sat_cnt0", cnt0, 7);
    @(negedge clk); chk("sat_hold", cnt0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
